// File: rtl/data_memory_if.sv
// data_memory_if: MEM-stage load/store bus between the pipeline and the data memory
interface data_memory_if;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WD;
    logic        StopM;
    logic [31:0] ReadDataM;
    logic        Halted;

    modport master (
        output MemWriteM, ALUOutM, WD, StopM,
        input  ReadDataM, Halted
    );

    modport slave (
        input  MemWriteM, ALUOutM, WD, StopM,
        output ReadDataM, Halted
    );
endinterface

// File: rtl/data_memory.sv
// data_memory: word-organised MIPS32 data memory with combinational read and sticky halt freeze.
// Optional DATA_MEMORY_DUMP_EN prints every word in binary once, on the edge where Halted rises.
module data_memory #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input logic         CLK,
    input logic         RstN,
    data_memory_if.slave bus
);
    logic [31:0]       mem_q [DEPTH];
    logic              halted_q;
    logic              halted_d;
    logic [ADDR_W-1:0] idx;
    logic              in_range;
    logic              wr_en;
    logic              unused_lo;

    assign idx           = bus.ALUOutM[ADDR_W+1:2];
    assign in_range      = ~|bus.ALUOutM[31:ADDR_W+2];
    assign unused_lo     = ^bus.ALUOutM[1:0];
    assign wr_en         = bus.MemWriteM && !halted_q && !bus.StopM && in_range;
    assign halted_d      = halted_q | bus.StopM;
    assign bus.ReadDataM = in_range ? mem_q[idx] : 32'h0;
    assign bus.Halted    = halted_q;

    // Halt flag is sticky until reset; stores land only while running and in range.
    always_ff @(posedge CLK or negedge RstN) begin
        if (!RstN) begin
            halted_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
        end else begin
            halted_q <= halted_d;
            if (wr_en) mem_q[idx] <= bus.WD;
        end
    end

`ifdef DATA_MEMORY_DUMP_EN
    // Simulation-only dump of pre-edge contents on the halt-rising edge.
    always @(posedge CLK) begin
        if (RstN && bus.StopM && !halted_q)
            for (int i = 0; i < DEPTH; i++) $display("%032b", mem_q[i]);
    end
`else
    // Dump disabled: no simulation output.
`endif
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: scoreboard-driven self-checking bench for data_memory
module tb_data_memory;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    logic [31:0] exp_q [$];

    data_memory_if bus ();

    data_memory #(.DEPTH(512), .ADDR_W(9)) dut (
        .CLK  (clk),
        .RstN (rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic s);
        @(negedge clk);
        bus.ALUOutM   = a;
        bus.WD        = d;
        bus.MemWriteM = 1'b1;
        bus.StopM     = s;
        @(posedge clk);
        #1;
        bus.MemWriteM = 1'b0;
        bus.StopM     = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        bus.ALUOutM   = a;
        bus.MemWriteM = 1'b0;
        exp_q.push_back(exp);
        #1;
        check(tag, bus.ReadDataM, exp_q.pop_front());
    endtask

    initial begin
        bus.MemWriteM = 1'b0;
        bus.ALUOutM   = 32'h40;
        bus.WD        = 32'h0;
        bus.StopM     = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_read", bus.ReadDataM, 32'h0);
        check("reset_halt", {31'h0, bus.Halted}, 32'h0);
        // store attempted while reset is held must be ignored
        @(negedge clk);
        bus.ALUOutM   = 32'h0;
        bus.WD        = 32'h77;
        bus.MemWriteM = 1'b1;
        @(posedge clk);
        #1;
        bus.MemWriteM = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd("write_in_reset", 32'h0, 32'h0);

        wr(32'h10, 32'hDEADBEEF, 1'b0);
        rd("rw_aligned", 32'h10, 32'hDEADBEEF);
        rd("rw_misaligned", 32'h13, 32'hDEADBEEF);

        wr(32'h10, 32'h1, 1'b0);
        @(negedge clk);
        bus.ALUOutM   = 32'h10;
        bus.WD        = 32'h2;
        bus.MemWriteM = 1'b1;
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h2);
        #1;
        check("raw_before", bus.ReadDataM, exp_q.pop_front());
        @(posedge clk);
        #1;
        bus.MemWriteM = 1'b0;
        check("raw_after", bus.ReadDataM, exp_q.pop_front());

        wr(32'h800, 32'h5555, 1'b0);
        rd("oor_read", 32'h800, 32'h0);
        rd("oor_word0", 32'h0, 32'h0);
        rd("oor_word4", 32'h10, 32'h2);
        rd("oor_high", 32'h8000_0010, 32'h0);
        wr(32'h7FC, 32'h11, 1'b0);
        rd("last_word", 32'h7FC, 32'h11);
        rd("last_word_alias", 32'h7FF, 32'h11);

        check("pre_stop_halt", {31'h0, bus.Halted}, 32'h0);
        wr(32'h20, 32'h7, 1'b1);
        check("stop_halt", {31'h0, bus.Halted}, 32'h1);
        rd("stop_store_dropped", 32'h20, 32'h0);
        wr(32'h24, 32'h9, 1'b0);
        rd("halt_store_dropped", 32'h24, 32'h0);
        check("halt_sticky", {31'h0, bus.Halted}, 32'h1);
        rd("halt_read_ok", 32'h10, 32'h2);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_clears_halt", {31'h0, bus.Halted}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd("rst_clears_word4", 32'h10, 32'h0);
        wr(32'h0, 32'hAB, 1'b0);
        rd("store_ab", 32'h0, 32'hAB);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_read", bus.ReadDataM, 32'h0);
        check("midrun_rst_halt", {31'h0, bus.Halted}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wr(32'h0, 32'h3, 1'b0);
        rd("resume_write", 32'h0, 32'h3);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
